// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
// master = producer/consumer side (decode and writeback), slave = the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [5:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (
    output in_valid, in1, in2, sel, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in1, in2, sel, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: DLX-style ALU with a registered valid/ready result stage.
// Define ALU_PIPE_MUL_EN to add the iterative shift-add multiplier (sel 101000).
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);
  // state  | meaning
  // S_IDLE | single-cycle ops accepted while the result slot is empty or draining
  // S_MUL  | shift-add multiply in flight, one multiplier bit per cycle

  localparam logic [5:0] OP_AND = 6'b000000;
  localparam logic [5:0] OP_OR  = 6'b000001;
  localparam logic [5:0] OP_XOR = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000100;
  localparam logic [5:0] OP_SRL = 6'b000101;
  localparam logic [5:0] OP_SLL = 6'b000110;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SEQ = 6'b110000;
  localparam logic [5:0] OP_SNE = 6'b110001;
  localparam logic [5:0] OP_SLT = 6'b110010;
  localparam logic [5:0] OP_SGT = 6'b110011;
  localparam logic [5:0] OP_SLE = 6'b110100;
  localparam logic [5:0] OP_SGE = 6'b110110;
  localparam logic [5:0] OP_SUB = 6'b111000;

  function automatic logic [WIDTH-1:0] alu_result(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [5:0]       op
  );
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] r;
    amt = b[SHW-1:0];
    r   = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SRA: r = $signed(a) >>> amt;
      OP_SRL: r = a >> amt;
      OP_SLL: r = a << amt;
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_SEQ: r = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SNE: r = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
      OP_SGT: r = {{(WIDTH-1){1'b0}}, ($signed(a) >  $signed(b))};
      OP_SLE: r = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
      OP_SGE: r = {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             in_ready;
  logic             accept;

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready;
  assign accept        = bus.in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [5:0] OP_MUL = 6'b101000;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      state       <= S_IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.sel == OP_MUL) begin
              state  <= S_MUL;
              cnt    <= SHW'(WIDTH - 1);
              mcand  <= bus.in1;
              mplier <= bus.in2;
              acc    <= '0;
            end else begin
              out_q       <= alu_result(bus.in1, bus.in2, bus.sel);
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // slot is guaranteed free here: MUL is only accepted when it drains
          if (cnt == '0) begin
            out_q       <= acc_next;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
      endcase
    end
  end
`else
  assign in_ready = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        out_q       <= alu_result(bus.in1, bus.in2, bus.sel);
        out_valid_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a behavioural model.
// MUL scenarios are built when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_pipe_if #(.WIDTH(32)) bus ();

  alu_pipe #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] s);
    int          n;
    logic [63:0] p;
    n = int'(b % 32);
    p = {32'd0, a} * {32'd0, b};
    case (s)
      6'b000000: return a & b;
      6'b000001: return a | b;
      6'b000010: return a ^ b;
      6'b000100: return (a >> n) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> n) : 32'd0);
      6'b000101: return a >> n;
      6'b000110: return a << n;
      6'b100000: return a + b;
      6'b111000: return a - b;
      6'b110000: return (a == b) ? 32'd1 : 32'd0;
      6'b110001: return (a != b) ? 32'd1 : 32'd0;
      6'b110010: return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      6'b110011: return ($signed(a) >  $signed(b)) ? 32'd1 : 32'd0;
      6'b110100: return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      6'b110110: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_PIPE_MUL_EN
      6'b101000: return p[31:0];
`endif
      default:   return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out !== 32'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: out=%h out_valid=%b in_ready=%b, required 0/0/1",
               bus.out, bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    logic [31:0] ta [16];
    logic [31:0] tb [16];
    logic [5:0]  ts [16];
    logic [31:0] te [16];
    ta = '{32'hFFFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
           32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h1234, 32'h1234, 32'hDEAD_BEEF};
    tb = '{32'd1, 32'd7, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
           32'h21, 32'd4, 32'd4, 32'd0,
           32'd1, 32'd1, 32'd1, 32'd1,
           32'h1234, 32'h1234, 32'h1};
    ts = '{6'b100000, 6'b111000, 6'b000000, 6'b000001, 6'b000010,
           6'b000110, 6'b000100, 6'b000101, 6'b000110,
           6'b110010, 6'b110011, 6'b110100, 6'b110110,
           6'b110000, 6'b110001, 6'b111111};
    te = '{32'h0, 32'hFFFF_FFFE, 32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
           32'h2, 32'hF800_0000, 32'h0800_0000, 32'h8000_0001,
           32'd1, 32'd0, 32'd1, 32'd0,
           32'd1, 32'd0, 32'd0};
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== te[i-1]) begin
          errors++;
          $display("FAIL alu_op[%0d] sel=%b: out=%h valid=%b, required %h valid=1",
                   i-1, ts[i-1], bus.out, bus.out_valid, te[i-1]);
        end
      end
      if (i < 16) begin
        bus.in_valid = 1'b1;
        bus.in1 = ta[i];
        bus.in2 = tb[i];
        bus.sel = ts[i];
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL alu_throughput[%0d]: in_ready=%b, required 1", i, bus.in_ready);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_drain: out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [5:0]  codes [14];
    logic [31:0] q [$];
    logic        exp_ready;
    codes = '{6'b000000, 6'b000001, 6'b000010, 6'b000100, 6'b000101, 6'b000110, 6'b100000,
              6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100, 6'b110110, 6'b111000};
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (bus.out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid[%0d]: out_valid=%b, required %b", c, bus.out_valid, q.size() != 0);
      end else if (q.size() != 0) begin
        checks++;
        if (bus.out !== q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: out=%h, required %h", c, bus.out, q[0]);
        end
      end
      bus.out_ready = ($urandom_range(3, 0) != 0);
      bus.in_valid  = ($urandom_range(3, 0) != 0) && (c < 396);
      bus.in1 = $urandom;
      bus.in2 = (c % 5 == 0) ? ($urandom & 32'h3F) : $urandom;
      if (c % 7 == 0) bus.in2 = bus.in1;
      if ($urandom_range(1, 0) != 0) bus.sel = codes[$urandom_range(13, 0)];
      else bus.sel = 6'($urandom);
`ifdef ALU_PIPE_MUL_EN
      if (bus.sel == 6'b101000) bus.sel = 6'b111111;
`endif
      #1;
      exp_ready = (q.size() == 0) || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready[%0d]: in_ready=%b, required %b", c, bus.in_ready, exp_ready);
      end
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && exp_ready) q.push_back(ref_op(bus.in1, bus.in2, bus.sel));
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in1 = 32'd1;
    bus.in2 = 32'd2;
    bus.sel = 6'b100000;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in1 = 32'd10;
    bus.in2 = 32'd20;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== 32'd3) begin
        errors++;
        $display("FAIL backpressure[%0d]: in_ready=%b valid=%b out=%h, required 0/1/00000003",
                 i, bus.in_ready, bus.out_valid, bus.out);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 32'd30) begin
      errors++;
      $display("FAIL bp_next_op: valid=%b out=%h, required 1/0000001e", bus.out_valid, bus.out);
    end
    @(negedge clk);
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic scramble);
    logic [31:0] exp;
    exp = ref_op(a, b, 6'b101000);
    bus.in_valid = 1'b1;
    bus.in1 = 32'd7;
    bus.in2 = 32'd9;
    bus.sel = 6'b100000;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in1 = a;
    bus.in2 = b;
    bus.sel = 6'b101000;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_accept_ready: in_ready=%b, required 1", bus.in_ready);
    end
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (n < 32) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL mul_busy[%0d]: valid=%b in_ready=%b, required 0/0",
                   n, bus.out_valid, bus.in_ready);
        end
        if (scramble) begin
          bus.in1 = $urandom;
          bus.in2 = $urandom;
          bus.sel = 6'($urandom);
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== exp) begin
          errors++;
          $display("FAIL mul_result: valid=%b out=%h, required 1/%h", bus.out_valid, bus.out, exp);
        end
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_mul(32'h0001_0003, 32'h0002_0005, 1'b1);
    for (int i = 0; i < 4; i++) run_mul($urandom, $urandom, 1'b1);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in1 = 32'h0001_0003;
    bus.in2 = 32'h0002_0005;
    bus.sel = 6'b101000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_mul: valid=%b in_ready=%b out=%h, required 0/1/0",
               bus.out_valid, bus.in_ready, bus.out);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1 = 32'd2;
    bus.in2 = 32'd3;
    bus.sel = 6'b100000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 32'd5) begin
      errors++;
      $display("FAIL add_after_reset: valid=%b out=%h, required 1/00000005", bus.out_valid, bus.out);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_mul_completed: out_valid=%b, required 0", bus.out_valid);
    end
  endtask
`else
  task automatic test_mul_undefined();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in1 = 32'h0001_0003;
    bus.in2 = 32'h0002_0005;
    bus.sel = 6'b101000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 32'd0) begin
      errors++;
      $display("FAIL mul_undefined: valid=%b out=%h, required 1/00000000", bus.out_valid, bus.out);
    end
    bus.in_valid = 1'b1;
    bus.sel = 6'b100000;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_undefined_ready: in_ready=%b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b out=%h, required 0/0", bus.out_valid, bus.out);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_alu_ops();
    test_random();
    test_backpressure();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_mul_undefined();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the combinational DLX-style `alu`. It takes the same six-bit `sel` operation encoding and the same operand semantics, generalised to `WIDTH` bits, and registers the result behind a valid/ready output stage. An optional iterative shift-add multiplier is also provided. It sits between the decode/operand-fetch stage and writeback of the integer datapath and can absorb writeback back-pressure.

## Interface
- `WIDTH`, 32: operand and result width; ≥ 4, power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `in_valid  in  1`: operation presented on `in1`/`in2`/`sel`.
- `in_ready  out  1`: block can accept; an operation is accepted when `in_valid && in_ready` at a rising edge.
- `in1  in  WIDTH`: operand A.
- `in2  in  WIDTH`: operand B; bits `[SHW-1:0]` are the shift amount for shifts.
- `sel  in  6`: operation, `{sel5..sel0}`.
- `out_valid  out  1`: `out` holds an unconsumed result.
- `out_ready  in  1`: consumer takes `out` when `out_valid && out_ready` at a rising edge.
- `out  out  WIDTH`: registered result.

## Operation
- `sel` encoding, binary: AND 000000, OR 000001, XOR 000010, SRA 000100, SRL 000101, SLL 000110, ADD 100000, SEQ 110000, SNE 110001, SLT 110010, SGT 110011, SLE 110100, SGE 110110, SUB 111000, MUL 101000 (macro only). Any other code produces result 0 with the normal 1-cycle latency.
- ADD and SUB are modulo 2^WIDTH; carry and overflow are discarded.
- Compares are two's-complement signed and give 1 or 0, zero-extended to WIDTH.
- Shifts use only `in2[SHW-1:0]`; upper bits of `in2` are ignored. SRA replicates `in1[WIDTH-1]`. A shift by 0 returns `in1` unchanged.
- MUL returns the low WIDTH bits of `in1*in2`, i.e. the unsigned product truncated; this equals the signed product truncated.
- FSM states:
  - IDLE: `in_ready = !out_valid || out_ready`.
  - MUL: `in_ready = 0`. Holds a bit counter, a multiplicand register shifting left, a multiplier register shifting right, and an accumulator.
- Transitions:
  - IDLE→MUL on accepting a MUL.
  - MUL→IDLE when the counter finishes WIDTH bits; the accumulator is written to `out` and `out_valid` is set.
- Output register: `out_valid` clears on a handshake unless a new result is written on the same edge. A new result overwrites `out` only when the register is empty or being consumed on that edge. A held result never changes while `out_valid && !out_ready`.
- Operands are captured at acceptance. Later changes to `in1`, `in2` or `sel` do not affect an in-flight MUL.

## Timing
- Reset values: `out = 0`, `out_valid = 0`, FSM = IDLE, counter = 0. `in_ready` resets to 1, combinational from state.
- Non-MUL operation accepted at edge k: `out`/`out_valid` are visible after edge k (latency 1). Full throughput is 1 op/cycle when `out_ready = 1`.
- MUL accepted at edge k: edges k+1..k+WIDTH each process one multiplier bit, LSB first. The result is visible after edge k+WIDTH, so latency is WIDTH.
- Consuming a previous result on edge k while accepting a MUL on edge k: `out_valid` is 0 during the MUL.
- Back-pressure: with `out_valid = 1` and `out_ready = 0`, `in_ready = 0`, nothing is accepted and `out` is stable.
- `out_valid` is never asserted by the MUL completion while an older result is unconsumed. This cannot happen, because MUL is only accepted when the slot will be free.
- `rst_n` low at any time, including mid-MUL: the in-flight operation is abandoned immediately (asynchronously) and all reset values apply. The first acceptance is possible at the first rising edge with `rst_n` high.
- No combinational path from `in_valid`/operands to `out`. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `ALU_PIPE_MUL_EN` defined: sel 101000 is the iterative multiplier described above; the MUL FSM state, counter and shift registers are present.
- Undefined: no multiplier hardware and the FSM is permanently IDLE. 101000 is an undefined code (result 0, latency 1). `in_ready = !out_valid || out_ready` always.

## Test plan
All scenarios use WIDTH = 32.
- ALU ops at 1/cycle with `out_ready = 1`:
  - ADD 0xFFFFFFFF+1 → 0x00000000.
  - SUB 5−7 → 0xFFFFFFFE.
  - AND/OR/XOR on 0xF0F0F0F0/0xFF00FF00 → 0xF000F000/0xFFF0FFF0/0x0FF00FF0.
  - Each result appears the cycle after acceptance.
- Shifts with `in1 = 0x80000001`:
  - SLL `in2 = 0x00000021`: amount 1 → 0x00000002.
  - SRA 4 → 0xF8000000.
  - SRL 4 → 0x08000000.
  - SLL 0 → 0x80000001.
- Signed compares with `in1 = 0xFFFFFFFF` (−1), `in2 = 1`:
  - SLT → 1, SGT → 0, SLE → 1, SGE → 0.
  - SEQ on equal operands → 1, SNE → 0.
  - `sel = 111111` → 0.
- Back-pressure: hold `out_ready = 0` for 5 cycles after an ADD result.
  - `in_ready` stays 0 and `out` is stable.
  - Raising `out_ready` consumes the result and accepts the next op on the same edge.
- MUL (`ALU_PIPE_MUL_EN`): 0x00010003 × 0x00020005 → 0x000B000F.
  - `out_valid` rises exactly 32 cycles after acceptance; `in_ready = 0` throughout.
  - Operand changes mid-MUL are ignored.
- Reset mid-MUL at cycle 10 of 32: `out_valid = 0` and `in_ready = 1` immediately. A following ADD 2+3 → 5 at latency 1. Without the macro, sel 101000 → 0 at latency 1.
